spi_txn_arbiter: RTL and testbench

- Shares one SPIMaster-style byte engine between NUM_REQ on-chip requesters, such as accelerator cores or the AHB SPI register front end.
- Arbitrates round-robin and drives slave select, enable, write data and byte count for exactly one transaction at a time.
- Detects completion from the engine's returned byte count and sends read data back to the winning requester.
- Guards each transaction with SS setup/release delays and a watchdog timeout.

---
 rtl/spi_txn_arbiter.sv | 230 +++++++++++++++++++++++
 tb/tb_spi_txn_arbiter.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_txn_arbiter.sv
// Round-robin arbiter sharing one SPI byte engine between NUM_REQ requesters.
// Optional SS lock/back-to-back mode is enabled with `define SPI_ARB_LOCK_EN.
module spi_txn_arbiter #(
    parameter int NUM_REQ        = 4,
    parameter int SS_WIDTH       = 32,
    parameter int SETUP_CYCLES   = 2,
    parameter int RELEASE_CYCLES = 2,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic                  HCLK,
    input  logic                  HRESETn,
    input  logic [NUM_REQ-1:0]    req_valid_i,
    output logic [NUM_REQ-1:0]    req_ready_o,
    input  logic [NUM_REQ*32-1:0] req_wdata_i,
    input  logic [NUM_REQ*3-1:0]  req_nbytes_i,
    input  logic [NUM_REQ*5-1:0]  req_ss_idx_i,
`ifdef SPI_ARB_LOCK_EN
    input  logic [NUM_REQ-1:0]    req_lock_i,
`endif
    output logic [NUM_REQ-1:0]    rsp_valid_o,
    output logic [31:0]           rsp_rdata_o,
    output logic                  rsp_error_o,
    output logic                  spi_enable_o,
    output logic                  spi_reset_fill_o,
    output logic [31:0]           spi_wdata_o,
    output logic [2:0]            spi_nbytes_o,
    output logic [SS_WIDTH-1:0]   spi_ss_o,
    input  logic [31:0]           spi_rdata_i,
    input  logic [2:0]            spi_rbytes_i,
    output logic                  busy_o
);

    localparam int PW   = $clog2(NUM_REQ);
    localparam int CMAX = (SETUP_CYCLES > RELEASE_CYCLES) ? SETUP_CYCLES : RELEASE_CYCLES;
    localparam int CW   = $clog2(CMAX + 1);
    localparam int WW   = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {IDLE, SETUP, XFER, RELEASE} state_t;

    state_t                state_q, state_d;
    logic [PW-1:0]         ptr_q, ptr_d, gnt_q, gnt_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [WW-1:0]         wdog_q, wdog_d;
    logic [31:0]           wdata_q, wdata_d, rdata_q, rdata_d;
    logic [2:0]            nbytes_q, nbytes_d;
    logic [SS_WIDTH-1:0]   ss_q, ss_d;
    logic [NUM_REQ-1:0]    ready_q, ready_d, rsp_valid_q, rsp_valid_d;
    logic                  en_q, en_d, err_q, err_d, fill_q, fill_d;
    logic                  err_pend_q, err_pend_d, lock_win_q, lock_win_d;

    logic                  found, sel_bad, done;
    logic [PW-1:0]         sel, cand;
    logic [2:0]            sel_nbytes;
    logic [4:0]            sel_ss;
    logic [31:0]           sel_wdata;
    logic [SS_WIDTH-1:0]   sel_ss_n;

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        gnt_d       = gnt_q;
        cnt_d       = cnt_q;
        wdog_d      = wdog_q;
        wdata_d     = wdata_q;
        nbytes_d    = nbytes_q;
        ss_d        = ss_q;
        en_d        = en_q;
        ready_d     = '0;
        rsp_valid_d = '0;
        rdata_d     = '0;
        err_d       = 1'b0;
        fill_d      = 1'b0;
        err_pend_d  = 1'b0;
        lock_win_d  = 1'b0;

        found = 1'b0;
        sel   = '0;
        cand  = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            cand = PW'((32'(ptr_q) + i) % NUM_REQ);
            if (!found && req_valid_i[cand]) begin
                found = 1'b1;
                sel   = cand;
            end
        end
        // A locked requester re-requesting in the window bypasses the pointer.
        if (lock_win_q) begin
            found = req_valid_i[gnt_q];
            sel   = gnt_q;
        end

        sel_wdata  = req_wdata_i[32*32'(sel) +: 32];
        sel_nbytes = req_nbytes_i[3*32'(sel) +: 3];
        sel_ss     = req_ss_idx_i[5*32'(sel) +: 5];
        sel_bad    = (sel_nbytes == 3'd0) || (sel_nbytes > 3'd4) || (32'(sel_ss) >= SS_WIDTH);
        for (int unsigned i = 0; i < SS_WIDTH; i++) begin
            sel_ss_n[i] = (i != 32'(sel_ss));
        end
        // Fill is cleared at the edge after the pulse, so a stale count must not complete.
        done = (spi_rbytes_i == nbytes_q) && !fill_q;

        case (state_q)
            IDLE: begin
                if (err_pend_q) begin
                    rsp_valid_d[gnt_q] = 1'b1;
                    err_d              = 1'b1;
                end else if (lock_win_q && !found) begin
                    ss_d    = '1;
                    state_d = RELEASE;
                    cnt_d   = '0;
                end else if (found) begin
                    ready_d[sel] = 1'b1;
                    gnt_d        = sel;
                    wdata_d      = sel_wdata;
                    nbytes_d     = sel_nbytes;
                    ptr_d        = (32'(sel) == NUM_REQ - 1) ? '0 : sel + 1'b1;
                    if (sel_bad) begin
                        err_pend_d = 1'b1;
                        ss_d       = '1;
                    end else begin
                        fill_d = 1'b1;
                        ss_d   = sel_ss_n;
                        if (lock_win_q) begin
                            state_d = XFER;
                            en_d    = 1'b1;
                            wdog_d  = '0;
                        end else begin
                            state_d = SETUP;
                            cnt_d   = '0;
                        end
                    end
                end
            end
            SETUP: begin
                if (cnt_q >= CW'(SETUP_CYCLES)) begin
                    state_d = XFER;
                    en_d    = 1'b1;
                    wdog_d  = '0;
                end else if (cnt_q != '1) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            XFER: begin
                if (done) begin
                    rdata_d            = spi_rdata_i;
                    rsp_valid_d[gnt_q] = 1'b1;
                    en_d               = 1'b0;
`ifdef SPI_ARB_LOCK_EN
                    if (req_lock_i[gnt_q]) begin
                        state_d    = IDLE;
                        lock_win_d = 1'b1;
                    end else
`endif
                    begin
                        ss_d    = '1;
                        state_d = RELEASE;
                        cnt_d   = '0;
                    end
                end else if (wdog_q >= WW'(TIMEOUT_CYCLES - 1)) begin
                    rsp_valid_d[gnt_q] = 1'b1;
                    err_d              = 1'b1;
                    en_d               = 1'b0;
                    ss_d               = '1;
                    state_d            = RELEASE;
                    cnt_d              = '0;
                end else if (wdog_q != '1) begin
                    wdog_d = wdog_q + 1'b1;
                end
            end
            RELEASE: begin
                if (cnt_q >= CW'(RELEASE_CYCLES - 1)) begin
                    state_d = IDLE;
                end else if (cnt_q != '1) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state_q     <= IDLE;
            ptr_q       <= '0;
            gnt_q       <= '0;
            cnt_q       <= '0;
            wdog_q      <= '0;
            wdata_q     <= '0;
            nbytes_q    <= '0;
            ss_q        <= '1;
            en_q        <= 1'b0;
            ready_q     <= '0;
            rsp_valid_q <= '0;
            rdata_q     <= '0;
            err_q       <= 1'b0;
            fill_q      <= 1'b0;
            err_pend_q  <= 1'b0;
            lock_win_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            gnt_q       <= gnt_d;
            cnt_q       <= cnt_d;
            wdog_q      <= wdog_d;
            wdata_q     <= wdata_d;
            nbytes_q    <= nbytes_d;
            ss_q        <= ss_d;
            en_q        <= en_d;
            ready_q     <= ready_d;
            rsp_valid_q <= rsp_valid_d;
            rdata_q     <= rdata_d;
            err_q       <= err_d;
            fill_q      <= fill_d;
            err_pend_q  <= err_pend_d;
            lock_win_q  <= lock_win_d;
        end
    end

    assign req_ready_o      = ready_q;
    assign rsp_valid_o      = rsp_valid_q;
    assign rsp_rdata_o      = rdata_q;
    assign rsp_error_o      = err_q;
    assign spi_enable_o     = en_q;
    assign spi_reset_fill_o = fill_q;
    assign spi_wdata_o      = wdata_q;
    assign spi_nbytes_o     = nbytes_q;
    assign spi_ss_o         = ss_q;
    assign busy_o           = (state_q != IDLE);

endmodule

// File: tb/tb_spi_txn_arbiter.sv
// Directed bench for spi_txn_arbiter with a response scoreboard and a small engine model.
// Define SPI_ARB_LOCK_EN to also exercise the SS lock mode.
module tb_spi_txn_arbiter;

    localparam int NR = 4;

    logic          HCLK = 1'b0;
    logic          HRESETn;
    logic [NR-1:0] req_valid_i;
    logic [NR-1:0] req_ready_o;
    logic [NR*32-1:0] req_wdata_i;
    logic [NR*3-1:0]  req_nbytes_i;
    logic [NR*5-1:0]  req_ss_idx_i;
`ifdef SPI_ARB_LOCK_EN
    logic [NR-1:0] req_lock_i;
`endif
    logic [NR-1:0] rsp_valid_o;
    logic [31:0]   rsp_rdata_o;
    logic          rsp_error_o;
    logic          spi_enable_o;
    logic          spi_reset_fill_o;
    logic [31:0]   spi_wdata_o;
    logic [2:0]    spi_nbytes_o;
    logic [31:0]   spi_ss_o;
    logic [31:0]   spi_rdata_i;
    logic [2:0]    spi_rbytes_i;
    logic          busy_o;

    always #5 HCLK = ~HCLK;

    spi_txn_arbiter #(
        .NUM_REQ(NR),
        .SS_WIDTH(32),
        .SETUP_CYCLES(2),
        .RELEASE_CYCLES(2),
        .TIMEOUT_CYCLES(64)
    ) dut (
        .HCLK(HCLK),
        .HRESETn(HRESETn),
        .req_valid_i(req_valid_i),
        .req_ready_o(req_ready_o),
        .req_wdata_i(req_wdata_i),
        .req_nbytes_i(req_nbytes_i),
        .req_ss_idx_i(req_ss_idx_i),
`ifdef SPI_ARB_LOCK_EN
        .req_lock_i(req_lock_i),
`endif
        .rsp_valid_o(rsp_valid_o),
        .rsp_rdata_o(rsp_rdata_o),
        .rsp_error_o(rsp_error_o),
        .spi_enable_o(spi_enable_o),
        .spi_reset_fill_o(spi_reset_fill_o),
        .spi_wdata_o(spi_wdata_o),
        .spi_nbytes_o(spi_nbytes_o),
        .spi_ss_o(spi_ss_o),
        .spi_rdata_i(spi_rdata_i),
        .spi_rbytes_i(spi_rbytes_i),
        .busy_o(busy_o)
    );

    typedef struct {
        logic [31:0] vld;
        logic [31:0] rdata;
        logic [31:0] err;
    } exp_t;

    exp_t        sb[$];
    int          checks = 0;
    int          failures = 0;
    int          eng_cnt = 0;
    int          eng_delay = 16;
    logic        eng_stall = 1'b0;
    logic [31:0] eng_rdata = 32'h0;
    logic        saw_en, saw_ss_low, saw_ss_high;
    int          last_wait;
    int          n;
    logic [31:0] wd [NR];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [31:0] vld, input logic [31:0] rdata, input logic [31:0] err);
        exp_t e;
        e.vld = vld; e.rdata = rdata; e.err = err;
        sb.push_back(e);
    endtask

    // One clock: check responses against the scoreboard, track activity, step the engine.
    task automatic tick();
        exp_t e;
        @(negedge HCLK);
        if (HRESETn && rsp_valid_o != '0) begin
            if (sb.size() == 0) begin
                chk("unexpected_rsp", 32'(rsp_valid_o), 32'h0);
            end else begin
                e = sb.pop_front();
                chk("rsp_valid", 32'(rsp_valid_o), e.vld);
                chk("rsp_rdata", rsp_rdata_o, e.rdata);
                chk("rsp_error", 32'(rsp_error_o), e.err);
            end
        end
        if (spi_enable_o) saw_en = 1'b1;
        if (spi_ss_o != '1) saw_ss_low = 1'b1;
        if (spi_ss_o == '1) saw_ss_high = 1'b1;
        if (!HRESETn) begin
            eng_cnt = 0; spi_rbytes_i = '0; spi_rdata_i = '0;
        end else if (spi_reset_fill_o) begin
            eng_cnt = 0; spi_rbytes_i = '0;
        end else if (spi_enable_o) begin
            eng_cnt++;
            if (eng_cnt >= eng_delay) begin
                spi_rbytes_i = eng_stall ? 3'd1 : spi_nbytes_o;
                spi_rdata_i  = eng_rdata ^ spi_wdata_o;
            end
        end
    endtask

    task automatic wait_ready(input logic [NR-1:0] exp, input string tag);
        int k = 0;
        do begin
            tick();
            k++;
        end while (req_ready_o == '0 && k < 200);
        last_wait = k;
        chk(tag, 32'(req_ready_o), 32'(exp));
    endtask

    task automatic wait_drain(input int budget, input string tag);
        int k = 0;
        while (sb.size() != 0 && k < budget) begin
            tick();
            k++;
        end
        chk(tag, 32'(sb.size()), 32'h0);
        sb.delete();
    endtask

    task automatic do_reset();
        HRESETn     = 1'b0;
        req_valid_i = '0;
`ifdef SPI_ARB_LOCK_EN
        req_lock_i  = '0;
`endif
        eng_stall   = 1'b0;
        repeat (3) tick();
        HRESETn = 1'b1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: simulation exceeded time bound");
        $fatal(1, "bench timed out");
    end

    initial begin
        HRESETn      = 1'b0;
        req_valid_i  = '0;
        req_wdata_i  = '0;
        req_nbytes_i = '0;
        req_ss_idx_i = '0;
        spi_rdata_i  = '0;
        spi_rbytes_i = '0;
`ifdef SPI_ARB_LOCK_EN
        req_lock_i   = '0;
`endif
        repeat (2) tick();
        chk("rst_ss", spi_ss_o, 32'hFFFF_FFFF);
        chk("rst_en", 32'(spi_enable_o), 32'h0);
        chk("rst_busy", 32'(busy_o), 32'h0);
        chk("rst_ready", 32'(req_ready_o), 32'h0);
        chk("rst_rsp", 32'(rsp_valid_o), 32'h0);
        chk("rst_fill", 32'(spi_reset_fill_o), 32'h0);
        chk("rst_wdata", spi_wdata_o, 32'h0);
        chk("rst_nbytes", 32'(spi_nbytes_o), 32'h0);
        do_reset();

        // Single request
        req_wdata_i[31:0] = 32'h0000_A5C3;
        req_nbytes_i[2:0] = 3'd2;
        req_ss_idx_i[4:0] = 5'd3;
        eng_delay = 16;
        eng_rdata = 32'h0000_9999;
        push(32'h1, 32'h0000_3C5A, 32'h0);
        req_valid_i = 4'b0001;
        wait_ready(4'b0001, "t1_accept");
        req_valid_i = '0;
        req_wdata_i[31:0] = 32'hDEAD_BEEF;
        chk("t1_ss_low", spi_ss_o, 32'hFFFF_FFF7);
        chk("t1_fill", 32'(spi_reset_fill_o), 32'h1);
        chk("t1_wdata", spi_wdata_o, 32'h0000_A5C3);
        chk("t1_nbytes", 32'(spi_nbytes_o), 32'h2);
        chk("t1_busy", 32'(busy_o), 32'h1);
        n = 0;
        do begin tick(); n++; end while (!spi_enable_o && n < 50);
        chk("t1_en_latency", 32'(n), 32'd3);
        wait_drain(100, "t1_drain");
        chk("t1_ss_release", spi_ss_o, 32'hFFFF_FFFF);
        chk("t1_en_off", 32'(spi_enable_o), 32'h0);

        // Contention: round-robin order and back-to-back spacing
        do_reset();
        eng_delay = 3;
        eng_rdata = 32'h5A5A_0F0F;
        for (int k = 0; k < NR; k++) begin
            wd[k] = 32'h1000_0001 * (k + 1);
            req_wdata_i[32*k +: 32] = wd[k];
            req_nbytes_i[3*k +: 3]  = 3'd3;
            req_ss_idx_i[5*k +: 5]  = 5'(k + 8);
        end
        for (int k = 0; k < 8; k++) push(32'h1 << (k % NR), eng_rdata ^ wd[k % NR], 32'h0);
        req_valid_i = 4'b1111;
        for (int k = 0; k < 8; k++) begin
            wait_ready(4'(1 << (k % NR)), "t2_grant");
            if (k == 1) chk("t2_b2b_cycles", 32'(last_wait), 32'd9);
        end
        req_valid_i = '0;
        wait_drain(100, "t2_drain");

        // Illegal requests: nbytes 0 and 5
        do_reset();
        saw_en = 1'b0; saw_ss_low = 1'b0;
        req_wdata_i[95:64] = 32'h1234_5678;
        req_ss_idx_i[14:10] = 5'd4;
        req_nbytes_i[8:6] = 3'd0;
        push(32'h4, 32'h0, 32'h1);
        req_valid_i = 4'b0100;
        wait_ready(4'b0100, "t3_accept_nb0");
        req_valid_i = '0;
        wait_drain(20, "t3_drain_nb0");
        req_nbytes_i[8:6] = 3'd5;
        push(32'h4, 32'h0, 32'h1);
        req_valid_i = 4'b0100;
        wait_ready(4'b0100, "t3_accept_nb5");
        req_valid_i = '0;
        wait_drain(20, "t3_drain_nb5");
        repeat (4) tick();
        chk("t3_no_enable", 32'(saw_en), 32'h0);
        chk("t3_no_ss", 32'(saw_ss_low), 32'h0);

        // Watchdog timeout with engine stalled at 1 of 4 bytes
        do_reset();
        req_wdata_i[63:32] = 32'hCAFE_0001;
        req_nbytes_i[5:3]  = 3'd4;
        req_ss_idx_i[9:5]  = 5'd7;
        eng_stall = 1'b1;
        eng_delay = 2;
        push(32'h2, 32'h0, 32'h1);
        req_valid_i = 4'b0010;
        wait_ready(4'b0010, "t4_accept");
        req_valid_i = '0;
        n = 0;
        while (!spi_enable_o && n < 20) begin tick(); n++; end
        n = 0;
        do begin tick(); n++; end while (rsp_valid_o == '0 && n < 200);
        chk("t4_timeout_cycles", 32'(n), 32'd64);
        chk("t4_en_off", 32'(spi_enable_o), 32'h0);
        chk("t4_ss_release", spi_ss_o, 32'hFFFF_FFFF);
        wait_drain(10, "t4_drain");
        eng_stall = 1'b0;

        // Asynchronous reset in the middle of a transfer
        do_reset();
        req_wdata_i[127:96] = 32'h0BAD_F00D;
        req_nbytes_i[11:9]  = 3'd2;
        req_ss_idx_i[19:15] = 5'd1;
        eng_delay = 1000;
        req_valid_i = 4'b1000;
        wait_ready(4'b1000, "t5_accept");
        req_valid_i = '0;
        n = 0;
        while (!spi_enable_o && n < 20) begin tick(); n++; end
        repeat (3) tick();
        chk("t5_en_before", 32'(spi_enable_o), 32'h1);
        #2 HRESETn = 1'b0;
        #1;
        chk("t5_rst_en", 32'(spi_enable_o), 32'h0);
        chk("t5_rst_ss", spi_ss_o, 32'hFFFF_FFFF);
        chk("t5_rst_busy", 32'(busy_o), 32'h0);
        tick();
        HRESETn = 1'b1;
        repeat (20) tick();
        chk("t5_idle_after", 32'(busy_o), 32'h0);
        eng_delay = 16;

`ifdef SPI_ARB_LOCK_EN
        // Locked back-to-back transactions from requester 1
        do_reset();
        eng_delay = 2;
        eng_rdata = 32'h0F0F_0F0F;
        req_lock_i = 4'b0010;
        req_wdata_i[63:32] = 32'h0000_00A1;
        req_nbytes_i[5:3]  = 3'd1;
        req_ss_idx_i[9:5]  = 5'd5;
        push(32'h2, 32'h0F0F_0F0F ^ 32'h0000_00A1, 32'h0);
        push(32'h2, 32'h0F0F_0F0F ^ 32'h0000_00A2, 32'h0);
        req_valid_i = 4'b0010;
        wait_ready(4'b0010, "t6_first");
        req_wdata_i[63:32] = 32'h0000_00A2;
        saw_ss_high = 1'b0;
        wait_ready(4'b0010, "t6_second");
        req_valid_i = '0;
        req_lock_i  = '0;
        chk("t6_ss_held", 32'(saw_ss_high), 32'h0);
        chk("t6_setup_skipped", 32'(spi_enable_o), 32'h1);
        chk("t6_ss_low", spi_ss_o, 32'hFFFF_FFDF);
        wait_drain(50, "t6_drain");
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
